ddc_acq_ctrl: RTL and testbench
===============================

Name: ddc_acq_ctrl

Overview:
- Acquisition controller and accumulator for the fs/4 digital downconverter.
- Sequences a burst of UNR=4-wide ADC words and applies the fs/4 cosine/sine patterns: cos = 1,0,-1,0; sin = 0,1,0,-1.
- Accumulates I/Q over a programmed number of carrier cycles and hands one result to the host over a valid/ready handshake.
- Sits between the ADC word stream and the host/readout logic.

Parameters:
- DWIDTH, 14, ADC sample width, unsigned.
- UNR, 4, samples per word. Must be 4; any other value is an elaboration error.
- NWIDTH, 16, width of the cycle-count register.
- AWIDTH, 32, signed accumulator width. Must be at least DWIDTH+2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts an acquisition when in IDLE.
- abort  in  1  single-cycle pulse; cancels acquisition from any state.
- num_cycles  in  NWIDTH  number of ADC words to accumulate; sampled on the accepted start.
- adc_data  in  [UNR][DWIDTH]  samples s0..s3, with s0 the oldest.
- adc_valid  in  1  adc_data is valid this cycle.
- busy  out  1  high in ARM, ACQ and FLUSH.
- i_acc  out  AWIDTH  signed I result.
- q_acc  out  AWIDTH  signed Q result.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts the result.
- overflow  out  1  sticky per acquisition; set if either accumulator exceeded its signed range.

Behaviour:
- Clocking: single clock; reset is asynchronous and active-low.
- Reset values: FSM=IDLE, busy=0, res_valid=0, i_acc=0, q_acc=0, overflow=0, internal counter=0.
- IDLE:
  - start with num_cycles!=0 → ARM. This latches num_cycles and clears the accumulators and overflow.
  - start with num_cycles==0 is ignored; the FSM stays in IDLE.
- ARM: one cycle, for accumulator clear → ACQ. adc_valid in this cycle is discarded.
- ACQ:
  - Each adc_valid word is accepted and the counter increments.
  - When the accepted count equals the latched N → FLUSH.
  - adc_valid low: the word is not counted and there is no timeout.
- Mix stage, registered (1 cycle):
  - mi = s0 - s2 and mq = s1 - s3.
  - Samples are zero-extended to DWIDTH+1; results are signed DWIDTH+1, sign-extended to AWIDTH.
- Accumulate stage: i_acc += mi and q_acc += mq, one cycle after the mix stage.
- FLUSH: waits for the pipeline to drain → HOLD.
- Latency: res_valid rises exactly 3 cycles after the clock edge that accepts the final word.
- HOLD:
  - res_valid=1; i_acc, q_acc and overflow are held stable.
  - The FSM returns to IDLE on the cycle where res_valid&&res_ready.
  - start during HOLD is ignored. No back-to-back start in the handshake cycle; the next start is honoured from IDLE.
- abort:
  - In ARM, ACQ or FLUSH: next state is IDLE, busy=0, and no res_valid is produced. The in-flight pipeline data is discarded and the accumulators keep their partial values.
  - In HOLD: drops res_valid and goes to IDLE.
  - abort takes priority over start in the same cycle.
- Overflow detection: an add whose operands have equal sign and whose result sign differs sets overflow. Without SAT_EN the accumulator wraps.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: DDC_ACQ_SAT_EN.
- Defined: accumulators saturate at +(2^(AWIDTH-1)-1) or -2^(AWIDTH-1) and stay clamped until the next start. overflow is still set.
- Undefined: two's-complement wrap, with overflow flagged only.

Decomposition:
- Package ddc_pkg holds:
  - UNR_C=4.
  - The state enum: IDLE, ARM, ACQ, FLUSH, HOLD.
  - The mix-width localparam DWIDTH+1.
  - A sat_add function, used under DDC_ACQ_SAT_EN.
- Sub-module ddc_mix_stage: the registered s0-s2 / s1-s3 computation with its valid bit. It is reusable by other fs/4 paths.

Test Plan:
1. Constant DC: all samples 1000, N=8 → i_acc=0, q_acc=0, overflow=0. res_valid rises 3 cycles after the 8th accepted word.
2. Cosine input: words {3000,2000,1000,2000}, N=4, adc_valid gapped every other cycle → i_acc=8000, q_acc=0. Gaps are not counted.
3. Sine input: words {2000,3000,2000,1000}, N=16 → i_acc=0, q_acc=32000.
4. Backpressure: hold res_ready=0 for 10 cycles in HOLD and pulse start → outputs remain stable and start is ignored. Then res_ready=1 → IDLE, res_valid=0 next cycle.
5. Abort: N=10, abort after 3 accepted words → busy=0 next cycle and res_valid never rises. A following start with N=2 on cosine words → i_acc=4000.
6. Overflow: AWIDTH=16 with words {16383,0,0,0}, N=3.
   - Undefined DDC_ACQ_SAT_EN → i_acc=-16387, overflow=1.
   - Defined → i_acc=32767, overflow=1.

Source files
------------

// File: rtl/ddc_pkg.sv
// Shared types and helpers for the fs/4 downconverter acquisition path.
// sat_add is only referenced when DDC_ACQ_SAT_EN is defined.
package ddc_pkg;

   localparam int unsigned UNR_C    = 4;
   localparam int unsigned DWIDTH_C = 14;
   localparam int unsigned MWIDTH_C = DWIDTH_C + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      ACQ   = 3'd2,
      FLUSH = 3'd3,
      HOLD  = 3'd4
   } state_t;

   // Mix result width for a given unsigned sample width (one extra bit of sign).
   function automatic int unsigned mix_width(input int unsigned dw);
      return dw + 1;
   endfunction

   // Signed add clamped to a w-bit two's-complement range (w <= 62).
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned w);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/ddc_acq_ctrl_mix.sv
// Registered fs/4 mix: mi = s0 - s2, mq = s1 - s3 on zero-extended samples.
// Reusable by any fs/4 path; clr drops an in-flight result.
module ddc_mix_stage
   import ddc_pkg::*;
#(
   parameter  int unsigned DWIDTH = 14,
   localparam int unsigned MW     = mix_width(DWIDTH)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          clr,
   input  logic                          in_valid,
   input  logic [UNR_C-1:0][DWIDTH-1:0]  data,
   output logic                          out_valid,
   output logic signed [MW-1:0]          mi,
   output logic signed [MW-1:0]          mq
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         mi        <= '0;
         mq        <= '0;
      end else begin
         out_valid <= in_valid && !clr;
         if (in_valid) begin
            mi <= $signed(MW'(data[0]) - MW'(data[2]));
            mq <= $signed(MW'(data[1]) - MW'(data[3]));
         end
      end
   end

endmodule

// File: rtl/ddc_acq_ctrl.sv
// Acquisition sequencer and I/Q accumulator for the fs/4 DDC with a
// valid/ready result handoff. DDC_ACQ_SAT_EN selects saturating accumulators.
module ddc_acq_ctrl
   import ddc_pkg::*;
#(
   parameter int unsigned DWIDTH = 14,
   parameter int unsigned UNR    = 4,
   parameter int unsigned NWIDTH = 16,
   parameter int unsigned AWIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [NWIDTH-1:0]           num_cycles,
   input  logic [UNR-1:0][DWIDTH-1:0]  adc_data,
   input  logic                        adc_valid,
   output logic                        busy,
   output logic signed [AWIDTH-1:0]    i_acc,
   output logic signed [AWIDTH-1:0]    q_acc,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        overflow
);

   localparam int unsigned MW = mix_width(DWIDTH);

   if (UNR != UNR_C) begin : g_unr_chk
      $error("ddc_acq_ctrl: UNR must be 4");
   end
   if (AWIDTH < DWIDTH + 2) begin : g_aw_chk
      $error("ddc_acq_ctrl: AWIDTH must be at least DWIDTH+2");
   end

   state_t                    state, next_state;
   logic [NWIDTH-1:0]         n_lat, cnt, cnt_inc;
   logic [1:0]                drain;
   logic                      start_acq_c, accept_c, acc_en_c;
   logic                      mix_valid;
   logic signed [MW-1:0]      mi, mq;
   logic signed [AWIDTH-1:0]  mi_ext, mq_ext, i_sum, q_sum;
   logic                      i_ovf, q_ovf;

   assign cnt_inc = cnt + NWIDTH'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next state; abort outranks every other request.
   always_comb begin
      next_state  = state;
      start_acq_c = 1'b0;
      accept_c    = 1'b0;
      case (state)
         IDLE:  if (!abort && start && num_cycles != '0) begin
                   next_state  = ARM;
                   start_acq_c = 1'b1;
                end
         ARM:   next_state = abort ? IDLE : ACQ;
         ACQ:   if (abort) next_state = IDLE;
                else if (adc_valid) begin
                   accept_c = 1'b1;
                   if (cnt_inc == n_lat) next_state = FLUSH;
                end
         FLUSH: if (abort) next_state = IDLE;
                else if (drain == 2'd2) next_state = HOLD;
         HOLD:  if (abort || res_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy      <= 1'b0;
         res_valid <= 1'b0;
         n_lat     <= '0;
         cnt       <= '0;
         drain     <= '0;
      end else begin
         busy      <= (next_state == ARM) || (next_state == ACQ) || (next_state == FLUSH);
         res_valid <= (next_state == HOLD);
         drain     <= (state == FLUSH) ? drain + 2'd1 : 2'd0;
         if (start_acq_c) begin
            n_lat <= num_cycles;
            cnt   <= '0;
         end else if (accept_c) begin
            cnt <= cnt_inc;
         end
      end
   end

   ddc_mix_stage #(.DWIDTH(DWIDTH)) u_mix (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (abort),
      .in_valid  (accept_c),
      .data      (adc_data),
      .out_valid (mix_valid),
      .mi        (mi),
      .mq        (mq)
   );

   assign acc_en_c = mix_valid && !abort;
   assign mi_ext   = {{(AWIDTH-MW){mi[MW-1]}}, mi};
   assign mq_ext   = {{(AWIDTH-MW){mq[MW-1]}}, mq};
   assign i_sum    = i_acc + mi_ext;
   assign q_sum    = q_acc + mq_ext;
   assign i_ovf    = (i_acc[AWIDTH-1] == mi_ext[AWIDTH-1]) && (i_sum[AWIDTH-1] != i_acc[AWIDTH-1]);
   assign q_ovf    = (q_acc[AWIDTH-1] == mq_ext[AWIDTH-1]) && (q_sum[AWIDTH-1] != q_acc[AWIDTH-1]);

`ifdef DDC_ACQ_SAT_EN
   // Once an accumulator clips it stays pinned until the next start.
   logic i_clamp, q_clamp;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_acc    <= '0;
         q_acc    <= '0;
         overflow <= 1'b0;
         i_clamp  <= 1'b0;
         q_clamp  <= 1'b0;
      end else if (start_acq_c) begin
         i_acc    <= '0;
         q_acc    <= '0;
         overflow <= 1'b0;
         i_clamp  <= 1'b0;
         q_clamp  <= 1'b0;
      end else if (acc_en_c) begin
         if (!i_clamp) i_acc <= AWIDTH'(sat_add(64'(i_acc), 64'(mi_ext), AWIDTH));
         if (!q_clamp) q_acc <= AWIDTH'(sat_add(64'(q_acc), 64'(mq_ext), AWIDTH));
         i_clamp  <= i_clamp || i_ovf;
         q_clamp  <= q_clamp || q_ovf;
         overflow <= overflow || (i_ovf && !i_clamp) || (q_ovf && !q_clamp);
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_acc    <= '0;
         q_acc    <= '0;
         overflow <= 1'b0;
      end else if (start_acq_c) begin
         i_acc    <= '0;
         q_acc    <= '0;
         overflow <= 1'b0;
      end else if (acc_en_c) begin
         i_acc    <= i_sum;
         q_acc    <= q_sum;
         overflow <= overflow || i_ovf || q_ovf;
      end
   end
`endif

endmodule

// File: tb/tb_ddc_acq_ctrl.sv
// Directed self-checking bench for ddc_acq_ctrl (AWIDTH=16 so overflow is reachable).
module tb_ddc_acq_ctrl;

   logic                      clk;
   logic                      reset_n;
   logic                      start;
   logic                      abort;
   logic [15:0]               num_cycles;
   logic [3:0][13:0]          adc_data;
   logic                      adc_valid;
   logic                      busy;
   logic signed [15:0]        i_acc;
   logic signed [15:0]        q_acc;
   logic                      res_valid;
   logic                      res_ready;
   logic                      overflow;

   int errors = 0;
   int checks = 0;

   ddc_acq_ctrl #(.DWIDTH(14), .UNR(4), .NWIDTH(16), .AWIDTH(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .num_cycles (num_cycles),
      .adc_data   (adc_data),
      .adc_valid  (adc_valid),
      .busy       (busy),
      .i_acc      (i_acc),
      .q_acc      (q_acc),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int s0, input int s1, input int s2, input int s3);
      adc_data[0] = 14'(s0);
      adc_data[1] = 14'(s1);
      adc_data[2] = 14'(s2);
      adc_data[3] = 14'(s3);
   endtask

   // Runs one acquisition into HOLD; a junk word is offered in the ARM cycle.
   task automatic run_acq(input string tag, input int s0, input int s1, input int s2,
                          input int s3, input int n, input bit gap);
      num_cycles = 16'(n);
      start      = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy"}, longint'(busy), 1);
      set_word(16383, 0, 0, 16383);
      adc_valid = 1'b1;
      tick();
      set_word(s0, s1, s2, s3);
      for (int k = 0; k < n; k++) begin
         if (gap) begin
            adc_valid = 1'b0;
            tick();
            adc_valid = 1'b1;
         end
         tick();
      end
      adc_valid = 1'b0;
      check({tag, "_lat0"}, longint'(res_valid), 0);
      tick();
      tick();
      check({tag, "_lat2"}, longint'(res_valid), 0);
      tick();
      check({tag, "_lat3"}, longint'(res_valid), 1);
      check({tag, "_hold_busy"}, longint'(busy), 0);
   endtask

   task automatic release_res(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, "_rel_valid"}, longint'(res_valid), 0);
      check({tag, "_rel_busy"}, longint'(busy), 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      num_cycles = '0;
      adc_valid  = 1'b0;
      res_ready  = 1'b0;
      set_word(0, 0, 0, 0);
      tick();
      tick();
      check("rst_busy", longint'(busy), 0);
      check("rst_valid", longint'(res_valid), 0);
      check("rst_i", longint'(i_acc), 0);
      check("rst_q", longint'(q_acc), 0);
      check("rst_ovf", longint'(overflow), 0);
      reset_n = 1'b1;
      tick();

      // Zero-length start and start+abort are both ignored.
      num_cycles = 16'd0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("n0_busy", longint'(busy), 0);
      num_cycles = 16'd4;
      start      = 1'b1;
      abort      = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("abort_prio_busy", longint'(busy), 0);

      // DC input cancels in both rails.
      run_acq("dc", 1000, 1000, 1000, 1000, 8, 1'b0);
      check("dc_i", longint'(i_acc), 0);
      check("dc_q", longint'(q_acc), 0);
      check("dc_ovf", longint'(overflow), 0);
      release_res("dc");

      // Cosine with gapped valid: 4 * (3000-1000).
      run_acq("cos", 3000, 2000, 1000, 2000, 4, 1'b1);
      check("cos_i", longint'(i_acc), 8000);
      check("cos_q", longint'(q_acc), 0);
      release_res("cos");

      // Sine: 16 * (3000-1000) on Q.
      run_acq("sin", 2000, 3000, 2000, 1000, 16, 1'b0);
      check("sin_i", longint'(i_acc), 0);
      check("sin_q", longint'(q_acc), 32000);
      check("sin_ovf", longint'(overflow), 0);

      // Backpressure in HOLD; start must be ignored.
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            num_cycles = 16'd5;
            start      = 1'b1;
         end
         tick();
         start = 1'b0;
         check("bp_valid", longint'(res_valid), 1);
         check("bp_q", longint'(q_acc), 32000);
      end
      release_res("bp");
      tick();
      check("bp_nostart", longint'(busy), 0);

      // Abort after 3 accepted words; the in-flight third word is dropped.
      num_cycles = 16'd10;
      start      = 1'b1;
      tick();
      start = 1'b0;
      set_word(3000, 2000, 1000, 2000);
      adc_valid = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) tick();
      abort = 1'b1;
      tick();
      abort     = 1'b0;
      adc_valid = 1'b0;
      check("ab_busy", longint'(busy), 0);
      for (int c = 0; c < 6; c++) begin
         tick();
         check("ab_novalid", longint'(res_valid), 0);
      end
      check("ab_partial_i", longint'(i_acc), 4000);
      run_acq("ab2", 3000, 2000, 1000, 2000, 2, 1'b0);
      check("ab2_i", longint'(i_acc), 4000);
      check("ab2_q", longint'(q_acc), 0);
      release_res("ab2");

      // Overflow on a 16-bit accumulator: 3 * 16383.
      run_acq("ovf", 16383, 0, 0, 0, 3, 1'b0);
`ifdef DDC_ACQ_SAT_EN
      check("ovf_i", longint'(i_acc), 32767);
`else
      check("ovf_i", longint'(i_acc), -16387);
`endif
      check("ovf_flag", longint'(overflow), 1);
      release_res("ovf");

      // Next start clears overflow.
      run_acq("clr", 16383, 0, 0, 0, 1, 1'b0);
      check("clr_i", longint'(i_acc), 16383);
      check("clr_ovf", longint'(overflow), 0);
      release_res("clr");

      // Asynchronous reset mid-acquisition.
      num_cycles = 16'd20;
      start      = 1'b1;
      tick();
      start = 1'b0;
      set_word(3000, 2000, 1000, 2000);
      adc_valid = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      reset_n = 1'b0;
      #1;
      check("mrst_busy", longint'(busy), 0);
      check("mrst_i", longint'(i_acc), 0);
      check("mrst_valid", longint'(res_valid), 0);
      adc_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      check("mrst_idle", longint'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
